// File: rtl/lfsr_range_gen.sv
// Galois LFSR random source with a req/valid/ack draw port returning values in [0, range_lim-1].
// Optional LFSR_ZERO_GUARD_EN: never let the state sit at all-zero.
module lfsr_range_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = 32'h80200003,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h1,
  parameter int               RW           = 8,
  parameter int               MAX_TRIES    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed,
  input  logic             lfsr_enable,
  output logic [WIDTH-1:0] lfsr_out,
  input  logic             req,
  input  logic [RW-1:0]    range_lim,
  output logic             busy,
  output logic             rand_valid,
  output logic [RW-1:0]    rand_out,
  input  logic             rand_ack,
  output logic             err
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, GEN, VALID} st_e;

  st_e              st_q, st_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [RW-1:0]    lim_q, lim_d;
  logic [RW-1:0]    mask_q, mask_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [RW-1:0]    rand_q, rand_d;
  logic             err_q, err_d;
  logic [RW-1:0]    cand;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Smear the top set bit downwards: smallest 2^k-1 covering x.
  function automatic logic [RW-1:0] smear(input logic [RW-1:0] x);
    logic [RW-1:0] m;
    m = x;
    for (int i = 0; i < RW; i++) m = m | (m >> 1);
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    if (load_seed)        state_d = seed;
    else if (st_q == GEN) state_d = step(state_q);
    else if (lfsr_enable) state_d = step(state_q);
`ifdef LFSR_ZERO_GUARD_EN
    if (state_d == '0) state_d = DEFAULT_SEED;
`endif
  end

  always_comb begin
    st_d    = st_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    rand_d  = rand_q;
    err_d   = 1'b0;
    cand    = state_q[RW-1:0] & mask_q;
    case (st_q)
      IDLE: begin
        if (req) begin
          if (range_lim == '0) begin
            err_d = 1'b1;
          end else begin
            lim_d   = range_lim;
            mask_d  = smear(range_lim - RW'(1));
            tries_d = '0;
            st_d    = GEN;
          end
        end
      end
      GEN: begin
        if (cand < lim_q) begin
          rand_d = cand;
          st_d   = VALID;
        end else if (tries_q == LAST_TRY) begin
          // mask < 2*lim, so a single subtraction lands inside the range
          rand_d = cand - lim_q;
          st_d   = VALID;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      VALID: begin
        if (rand_ack) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st_q    <= IDLE;
      state_q <= DEFAULT_SEED;
      lim_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      rand_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      rand_q  <= rand_d;
      err_q   <= err_d;
    end
  end

  assign lfsr_out   = state_q;
  assign busy       = (st_q == GEN);
  assign rand_valid = (st_q == VALID);
  assign rand_out   = rand_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Scoreboard bench for lfsr_range_gen: 8-bit LFSR, taps 0xB8; second instance uses MAX_TRIES=1.
module tb_lfsr_range_gen;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       load_seed = 1'b0;
  logic [7:0] seed = '0;
  logic       lfsr_enable = 1'b0;
  logic       req1 = 1'b0, req2 = 1'b0;
  logic [7:0] range_lim = '0;
  logic       rand_ack = 1'b1;

  logic [7:0] lfsr1, lfsr2, out1, out2;
  logic       busy1, busy2, v1, v2, err1, err2;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 Clk = ~Clk;

  lfsr_range_gen #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .RW(8), .MAX_TRIES(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .load_seed(load_seed), .seed(seed), .lfsr_enable(lfsr_enable),
    .lfsr_out(lfsr1), .req(req1), .range_lim(range_lim), .busy(busy1), .rand_valid(v1),
    .rand_out(out1), .rand_ack(rand_ack), .err(err1));

  lfsr_range_gen #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .RW(8), .MAX_TRIES(1)) dut2 (
    .Clk(Clk), .Reset(Reset), .load_seed(load_seed), .seed(seed), .lfsr_enable(lfsr_enable),
    .lfsr_out(lfsr2), .req(req2), .range_lim(range_lim), .busy(busy2), .rand_valid(v2),
    .rand_out(out2), .rand_ack(rand_ack), .err(err2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitors: a result is consumed on a cycle where valid and ack are both high.
  always @(negedge Clk) begin
    if (v1 && rand_ack) begin
      if (q1.size() == 0) chk("dut1 unexpected result", {24'h0, out1}, 32'hFFFF_FFFF);
      else chk("dut1 rand_out", {24'h0, out1}, {24'h0, q1.pop_front()});
    end
    if (v2 && rand_ack) begin
      if (q2.size() == 0) chk("dut2 unexpected result", {24'h0, out2}, 32'hFFFF_FFFF);
      else chk("dut2 rand_out", {24'h0, out2}, {24'h0, q2.pop_front()});
    end
  end

  task automatic drive_edge();
    @(posedge Clk); #1;
  endtask

  task automatic load(input logic [7:0] s);
    load_seed = 1'b1; seed = s;
    drive_edge();
    load_seed = 1'b0;
  endtask

  // Issue one draw; returns how many sampled cycles the DUT stayed busy.
  task automatic draw(input int d, input logic [7:0] lim, input logic [7:0] exp, output int bcyc);
    bit done;
    bcyc = 0; done = 0;
    range_lim = lim;
    if (d == 1) begin q1.push_back(exp); req1 = 1'b1; end
    else begin q2.push_back(exp); req2 = 1'b1; end
    drive_edge();
    req1 = 1'b0; req2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if ((d == 1 ? busy1 : busy2)) bcyc++;
      if (!(d == 1 ? (busy1 | v1) : (busy2 | v2))) begin done = 1; break; end
    end
    if (!done) chk("draw timeout", 32'd0, 32'd1);
    #1;
  endtask

  logic [7:0] fr_exp [6];
  int bc;

  initial begin
    fr_exp[0] = 8'h01; fr_exp[1] = 8'hB8; fr_exp[2] = 8'h5C;
    fr_exp[3] = 8'h2E; fr_exp[4] = 8'h17; fr_exp[5] = 8'hB3;

    #12;
    chk("reset lfsr_out", {24'h0, lfsr1}, 32'h01);
    chk("reset busy", {31'h0, busy1}, 32'h0);
    chk("reset rand_valid", {31'h0, v1}, 32'h0);
    chk("reset rand_out", {24'h0, out1}, 32'h0);
    chk("reset err", {31'h0, err1}, 32'h0);
    Reset = 1'b1;
    drive_edge();

    // Free-run: load edge then enabled steps.
    load_seed = 1'b1; seed = 8'h01; lfsr_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      load_seed = 1'b0;
      @(negedge Clk);
      chk($sformatf("free-run step %0d", i), {24'h0, lfsr1}, {24'h0, fr_exp[i]});
    end
    @(posedge Clk); #1;
    lfsr_enable = 1'b0;

    // First-try accepts.
    load(8'h01);
    draw(1, 8'd100, 8'd1, bc);
    chk("accept busy cycles", bc, 32'd1);
    chk("state after draw", {24'h0, lfsr1}, 32'hB8);
    draw(1, 8'd100, 8'd56, bc);

    // One rejection then accept.
    load(8'hB8);
    draw(1, 8'd50, 8'd28, bc);
    chk("reject busy cycles", bc, 32'd2);

    // Fallback with a single allowed try.
    load(8'hB8);
    draw(2, 8'd50, 8'd6, bc);
    chk("fallback busy cycles", bc, 32'd1);

    // range_lim == 0 flags err for one cycle and never goes busy.
    range_lim = 8'd0; req1 = 1'b1;
    drive_edge();
    req1 = 1'b0;
    @(negedge Clk);
    chk("err pulse", {31'h0, err1}, 32'h1);
    chk("err busy", {31'h0, busy1}, 32'h0);
    @(negedge Clk);
    chk("err cleared", {31'h0, err1}, 32'h0);
    #1;

    // range_lim == 1 with ack held off: result stays put, req in VALID ignored.
    rand_ack = 1'b0;
    range_lim = 8'd1; q1.push_back(8'd0); req1 = 1'b1;
    drive_edge();
    req1 = 1'b0;
    drive_edge();
    range_lim = 8'd5; req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk($sformatf("hold valid %0d", i), {31'h0, v1}, 32'h1);
      chk($sformatf("hold out %0d", i), {24'h0, out1}, 32'h0);
      chk($sformatf("hold busy %0d", i), {31'h0, busy1}, 32'h0);
      @(posedge Clk); #1;
    end
    req1 = 1'b0; rand_ack = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("valid drops after ack", {31'h0, v1}, 32'h0);
    chk("idle after ack", {31'h0, busy1}, 32'h0);
    #1;

    // Reset during GEN aborts the draw.
    load(8'hB8);
    range_lim = 8'd50; req1 = 1'b1;
    drive_edge();
    req1 = 1'b0;
    @(negedge Clk);
    chk("busy before reset", {31'h0, busy1}, 32'h1);
    Reset = 1'b0; #1;
    chk("mid-reset busy", {31'h0, busy1}, 32'h0);
    chk("mid-reset valid", {31'h0, v1}, 32'h0);
    chk("mid-reset rand_out", {24'h0, out1}, 32'h0);
    chk("mid-reset lfsr_out", {24'h0, lfsr1}, 32'h01);
    chk("mid-reset fallback out", {24'h0, out2}, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    drive_edge();

    // Zero seed.
    lfsr_enable = 1'b1;
    load(8'h00);
    @(negedge Clk);
`ifdef LFSR_ZERO_GUARD_EN
    chk("zero seed guarded", {24'h0, lfsr1}, 32'h01);
`else
    chk("zero seed loaded", {24'h0, lfsr1}, 32'h00);
`endif
    @(posedge Clk); #1;
    @(negedge Clk);
`ifdef LFSR_ZERO_GUARD_EN
    chk("zero seed then step", {24'h0, lfsr1}, 32'hB8);
`else
    chk("zero seed locked", {24'h0, lfsr1}, 32'h00);
`endif
    lfsr_enable = 1'b0;

    repeat (3) @(posedge Clk);
    chk("dut1 results outstanding", q1.size(), 32'd0);
    chk("dut2 results outstanding", q2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
